// File: rtl/rr_replay_loge_gate.sv
// Replay-side dependency gate: accumulates runtime loge events into per-(interface,channel)
// credit counters and releases each held replay entry once its required credits are covered.
module rr_replay_loge_gate #(
    parameter int LOGE_PER_INTERFACE = 5,
    parameter int NUM_INTERFACES     = 4,
    parameter int CNT_W              = 8
) (
    input  logic                                               clk,
    input  logic                                               rstn,
    input  logic [NUM_INTERFACES-1:0][LOGE_PER_INTERFACE-1:0]  rt_loge_in,
    input  logic                                               ent_valid,
    output logic                                               ent_ready,
    input  logic [NUM_INTERFACES*LOGE_PER_INTERFACE*CNT_W-1:0] ent_req,
    input  logic [LOGE_PER_INTERFACE-1:0]                      ent_chan,
    output logic                                               rel_valid,
    input  logic                                               rel_ready,
    output logic [LOGE_PER_INTERFACE-1:0]                      rel_chan,
    output logic                                               pending,
    output logic                                               err_overflow
);

    localparam int N = NUM_INTERFACES * LOGE_PER_INTERFACE;

    typedef enum logic [1:0] {IDLE, WAIT, REL} state_t;

    state_t                          state_q, state_d;
    logic   [CNT_W-1:0]              cnt_q [N];
    logic   [CNT_W-1:0]              cnt_d [N];
    logic   [CNT_W-1:0]              req_q [N];
    logic   [LOGE_PER_INTERFACE-1:0] chan_q;
    logic   [N-1:0]                  ev;
    logic   [N-1:0]                  ovf;
    logic                            sat;
    logic                            dec_en;
    logic                            accept;

    // Packed row flattens so that bit k = s*LOGE_PER_INTERFACE + c.
    assign ev     = rt_loge_in;
    assign accept = ent_valid && ent_ready;

    always_comb begin
        sat = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (cnt_q[k] < req_q[k]) sat = 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ent_ready = 1'b0;
        rel_valid = 1'b0;
        dec_en    = 1'b0;
        case (state_q)
            IDLE: begin
                ent_ready = 1'b1;
                if (ent_valid) state_d = WAIT;
            end
            WAIT: begin
                if (sat) begin
                    dec_en  = 1'b1;
                    state_d = REL;
                end
            end
            REL: begin
                rel_valid = 1'b1;
                if (rel_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One extra bit of headroom exposes overflow; subtraction only runs when sat holds, so it never wraps.
    for (genvar k = 0; k < N; k++) begin : g_cnt
        logic [CNT_W:0] wide;
        assign wide     = {1'b0, cnt_q[k]} + {{CNT_W{1'b0}}, ev[k]}
                        - (dec_en ? {1'b0, req_q[k]} : '0);
        assign ovf[k]   = wide[CNT_W];
        assign cnt_d[k] = wide[CNT_W] ? {CNT_W{1'b1}} : wide[CNT_W-1:0];
    end

    // NOTE: the counter and requirement arrays are control state, so they take the reset like any flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            chan_q       <= '0;
            err_overflow <= 1'b0;
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= '0;
                req_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            err_overflow <= err_overflow | (|ovf);
            for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
            if (accept) begin
                chan_q <= ent_chan;
                for (int k = 0; k < N; k++) req_q[k] <= ent_req[k*CNT_W +: CNT_W];
            end
        end
    end

    assign rel_chan = chan_q;
    assign pending  = (state_q != IDLE);

endmodule

// File: tb/tb_rr_replay_loge_gate.sv
// Directed bench for rr_replay_loge_gate: reset state, release latency, credit accounting,
// back-pressure, saturation and asynchronous reset.
module tb_rr_replay_loge_gate;

    localparam int L  = 5;
    localparam int NI = 4;
    localparam int CW = 8;
    localparam int N  = NI * L;

    logic                     clk;
    logic                     rstn;
    logic [NI-1:0][L-1:0]     rt_loge_in;
    logic                     ent_valid;
    logic                     ent_ready;
    logic [N*CW-1:0]          ent_req;
    logic [L-1:0]             ent_chan;
    logic                     rel_valid;
    logic                     rel_ready;
    logic [L-1:0]             rel_chan;
    logic                     pending;
    logic                     err_overflow;

    int checks = 0;
    int errors = 0;
    int mdl [N];

    typedef struct {
        int         k;
        int         pre;
        int         req;
        logic [4:0] chan;
    } vec_t;

    vec_t vecs [5];

    rr_replay_loge_gate #(
        .LOGE_PER_INTERFACE(L),
        .NUM_INTERFACES    (NI),
        .CNT_W             (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rt_loge_in  (rt_loge_in),
        .ent_valid   (ent_valid),
        .ent_ready   (ent_ready),
        .ent_req     (ent_req),
        .ent_chan    (ent_chan),
        .rel_valid   (rel_valid),
        .rel_ready   (rel_ready),
        .rel_chan    (rel_chan),
        .pending     (pending),
        .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*CW-1:0] mk_req(input int k, input int v);
        logic [N*CW-1:0] r;
        r = '0;
        r[k*CW +: CW] = CW'(v);
        return r;
    endfunction

    // Holds event bit k high for n consecutive cycles: n events.
    task automatic pulse(input int k, input int n);
        if (n > 0) begin
            rt_loge_in[k/L][k%L] = 1'b1;
            repeat (n) step();
            rt_loge_in[k/L][k%L] = 1'b0;
        end
    endtask

    // Returns one cycle after the handshake edge (gate now in WAIT).
    task automatic send_entry(input logic [N*CW-1:0] req, input logic [L-1:0] chan);
        ent_req   = req;
        ent_chan  = chan;
        ent_valid = 1'b1;
        check("ent_ready_before_hs", {31'b0, ent_ready}, 32'd1);
        step();
        ent_valid = 1'b0;
        ent_req   = '0;
        ent_chan  = '0;
    endtask

    initial begin
        rstn       = 1'b0;
        rt_loge_in = '0;
        ent_valid  = 1'b0;
        ent_req    = '0;
        ent_chan   = '0;
        rel_ready  = 1'b1;
        for (int k = 0; k < N; k++) mdl[k] = 0;

        vecs[0] = '{k: 0,  pre: 5, req: 2, chan: 5'b00001};
        vecs[1] = '{k: 0,  pre: 0, req: 3, chan: 5'b00001};
        vecs[2] = '{k: 13, pre: 1, req: 4, chan: 5'b00100};
        vecs[3] = '{k: 19, pre: 2, req: 2, chan: 5'b10000};
        vecs[4] = '{k: 7,  pre: 0, req: 0, chan: 5'b01000};

        // Reset values
        #12;
        check("rst_ent_ready", {31'b0, ent_ready}, 32'd1);
        check("rst_rel_valid", {31'b0, rel_valid}, 32'd0);
        check("rst_rel_chan", {27'b0, rel_chan}, 32'd0);
        check("rst_pending", {31'b0, pending}, 32'd0);
        check("rst_err", {31'b0, err_overflow}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // All-zero requirement: rel_valid at cycle 2, exactly one cycle
        send_entry('0, 5'b00100);
        check("zero_wait_pending", {31'b0, pending}, 32'd1);
        check("zero_wait_ready", {31'b0, ent_ready}, 32'd0);
        check("zero_wait_rel", {31'b0, rel_valid}, 32'd0);
        step();
        check("zero_rel_valid", {31'b0, rel_valid}, 32'd1);
        check("zero_rel_chan", {27'b0, rel_chan}, 32'h04);
        step();
        check("zero_rel_drop", {31'b0, rel_valid}, 32'd0);
        check("zero_idle", {31'b0, pending}, 32'd0);
        check("zero_idle_ready", {31'b0, ent_ready}, 32'd1);

        // req[1][W]=3 with no credits: waits, then releases 2 cycles after the third event
        send_entry(mk_req(6, 3), 5'b00010);
        for (int i = 0; i < 3; i++) begin
            check("w_hold_pending", {31'b0, pending}, 32'd1);
            check("w_hold_rel", {31'b0, rel_valid}, 32'd0);
            step();
        end
        pulse(6, 3);
        check("w_visibility_cycle", {31'b0, rel_valid}, 32'd0);
        step();
        check("w_rel_valid", {31'b0, rel_valid}, 32'd1);
        check("w_rel_chan", {27'b0, rel_chan}, 32'h02);
        step();
        check("w_cnt_zero", {24'b0, dut.cnt_q[6]}, 32'd0);

        // Table: preload credits, send entry, expect release now or after topping up
        for (int v = 0; v < 5; v++) begin
            pulse(vecs[v].k, vecs[v].pre);
            mdl[vecs[v].k] += vecs[v].pre;
            send_entry(mk_req(vecs[v].k, vecs[v].req), vecs[v].chan);
            check($sformatf("v%0d_pending", v), {31'b0, pending}, 32'd1);
            if (mdl[vecs[v].k] < vecs[v].req) begin
                check($sformatf("v%0d_wait", v), {31'b0, rel_valid}, 32'd0);
                pulse(vecs[v].k, vecs[v].req - mdl[vecs[v].k]);
                mdl[vecs[v].k] = vecs[v].req;
                check($sformatf("v%0d_late_wait", v), {31'b0, rel_valid}, 32'd0);
            end
            mdl[vecs[v].k] -= vecs[v].req;
            step();
            check($sformatf("v%0d_rel_valid", v), {31'b0, rel_valid}, 32'd1);
            check($sformatf("v%0d_rel_chan", v), {27'b0, rel_chan}, {27'b0, vecs[v].chan});
            step();
            check($sformatf("v%0d_idle", v), {31'b0, rel_valid}, 32'd0);
            check($sformatf("v%0d_cnt", v), {24'b0, dut.cnt_q[vecs[v].k]}, 32'(mdl[vecs[v].k]));
        end

        // Event arriving on the subtraction cycle is kept: cnt 2, req 2, +1 -> 1
        pulse(0, 2 - mdl[0]);
        send_entry(mk_req(0, 2), 5'b00001);
        rt_loge_in[0][0] = 1'b1;
        step();
        rt_loge_in[0][0] = 1'b0;
        check("same_cycle_rel", {31'b0, rel_valid}, 32'd1);
        step();
        check("same_cycle_cnt", {24'b0, dut.cnt_q[0]}, 32'd1);

        // Back-pressure: rel_valid / rel_chan stable for 10 cycles
        rel_ready = 1'b0;
        send_entry('0, 5'b01000);
        step();
        for (int i = 0; i < 10; i++) begin
            check("bp_rel_valid", {31'b0, rel_valid}, 32'd1);
            check("bp_rel_chan", {27'b0, rel_chan}, 32'h08);
            check("bp_ent_ready", {31'b0, ent_ready}, 32'd0);
            step();
        end
        rel_ready = 1'b1;
        step();
        check("bp_release_idle", {31'b0, pending}, 32'd0);
        check("bp_release_valid", {31'b0, rel_valid}, 32'd0);
        check("bp_release_ready", {31'b0, ent_ready}, 32'd1);

        // Saturation on [3][B]
        pulse(18, 255);
        check("sat_cnt_max", {24'b0, dut.cnt_q[18]}, 32'd255);
        check("sat_no_err_yet", {31'b0, err_overflow}, 32'd0);
        pulse(18, 1);
        check("sat_cnt_hold", {24'b0, dut.cnt_q[18]}, 32'd255);
        check("sat_err", {31'b0, err_overflow}, 32'd1);
        step();
        check("sat_err_sticky", {31'b0, err_overflow}, 32'd1);

        // Asynchronous reset mid-WAIT
        send_entry(mk_req(18, 1) | mk_req(6, 1), 5'b10000);
        check("mid_wait_pending", {31'b0, pending}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_pending", {31'b0, pending}, 32'd0);
        check("arst_ent_ready", {31'b0, ent_ready}, 32'd1);
        check("arst_rel_valid", {31'b0, rel_valid}, 32'd0);
        check("arst_rel_chan", {27'b0, rel_chan}, 32'd0);
        check("arst_err", {31'b0, err_overflow}, 32'd0);
        check("arst_cnt", {24'b0, dut.cnt_q[18]}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        check("post_rst_ready", {31'b0, ent_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
